// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit and the downstream type
// decoder: default reset PC, default buffer depth, RV32 major opcodes, the
// fetch FSM state type and the buffered entry layout.
package instr_fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam int          DEPTH_DEFAULT    = 2;

  // Major opcodes found in inst[6:0], consumed by the type decoder.
  localparam logic [6:0] OPC_LOAD     = 7'b000_0011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b000_1111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b001_0011;
  localparam logic [6:0] OPC_AUIPC    = 7'b001_0111;
  localparam logic [6:0] OPC_STORE    = 7'b010_0011;
  localparam logic [6:0] OPC_OP       = 7'b011_0011;
  localparam logic [6:0] OPC_LUI      = 7'b011_0111;
  localparam logic [6:0] OPC_BRANCH   = 7'b110_0011;
  localparam logic [6:0] OPC_JALR     = 7'b110_0111;
  localparam logic [6:0] OPC_JAL      = 7'b110_1111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b111_0011;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic        fault;
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  // Fault entries always carry a zero instruction word.
  function automatic fetch_entry_t fault_entry(input logic [31:0] pc);
    fetch_entry_t e;
    e.fault = 1'b1;
    e.pc    = pc;
    e.inst  = '0;
    return e;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bus bundle of the instruction fetch unit.
//   redirect_*   : flush + restart request from the back end
//   imem_req_*   : fetch request channel (valid/ready)
//   imem_rsp_*   : in-order response channel (no back-pressure)
//   inst_*       : instruction stream to the type decoder (valid/ready)
// modport master = the fetch unit, modport slave = its environment.
interface instr_fetch_unit_if;
  logic        redirect_valid_in;
  logic [31:0] redirect_pc_in;
  logic        imem_req_valid_out;
  logic [31:0] imem_req_addr_out;
  logic        imem_req_ready_in;
  logic        imem_rsp_valid_in;
  logic [31:0] imem_rsp_data_in;
  logic        imem_rsp_err_in;
  logic        inst_valid_out;
  logic [31:0] inst_out;
  logic [31:0] inst_pc_out;
  logic        inst_fault_out;
  logic        inst_ready_in;

  modport master (
    input  redirect_valid_in, redirect_pc_in,
    output imem_req_valid_out, imem_req_addr_out,
    input  imem_req_ready_in,
    input  imem_rsp_valid_in, imem_rsp_data_in, imem_rsp_err_in,
    output inst_valid_out, inst_out, inst_pc_out, inst_fault_out,
    input  inst_ready_in
  );

  modport slave (
    output redirect_valid_in, redirect_pc_in,
    input  imem_req_valid_out, imem_req_addr_out,
    output imem_req_ready_in,
    output imem_rsp_valid_in, imem_rsp_data_in, imem_rsp_err_in,
    input  inst_valid_out, inst_out, inst_pc_out, inst_fault_out,
    output inst_ready_in
  );
endinterface

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// fetch_fifo: synchronous FIFO with registered storage.
//   clk, rst   : clock, synchronous active-high reset (pointers/count only)
//   flush      : empties the FIFO; a same-cycle push lands as the only entry
//   push/push_data, pop : write / read strobes (pop on empty is ignored,
//                push on full is accepted only together with a pop)
//   head_data  : oldest entry, count/empty : occupancy
module fetch_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] cnt;
  logic             full, do_push, do_pop, wr_en;
  logic [PTR_W-1:0] wr_idx;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (cnt == '0);
  assign full    = (cnt == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign wr_en   = flush ? push : do_push;
  assign wr_idx  = flush ? '0 : wr_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= push ? ptr_inc('0) : '0;
      cnt    <= push ? CNT_W'(1) : '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      cnt <= cnt + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= push_data;
  end

  assign head_data = mem[rd_ptr];
  assign count     = cnt;

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: issues in-order instruction fetches and buffers the
// responses for the type decoder.
//   clk_in, rst_in : clock, synchronous active-high reset
//   bus (master)   : redirect, imem request/response, decoder stream
// Outstanding requests are counted by the in-flight PC FIFO itself; responses
// belonging to requests made before a redirect are counted in discard_cnt
// and dropped on arrival.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = DEPTH_DEFAULT
) (
  input logic               clk_in,
  input logic               rst_in,
  instr_fetch_unit_if.master bus
);
  localparam int               CNT_W   = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0]   DEPTH_L = (CNT_W + 1)'(DEPTH);

  fetch_state_e     state, state_next;
  logic [31:0]      pc;
  logic [CNT_W-1:0] discard_cnt, outstanding, buf_count;
  logic             buf_empty, pcq_empty;
  logic [31:0]      pcq_head;
  fetch_entry_t     buf_head, buf_push_data;
  logic             redirect, misaligned, req_valid, req_fire;
  logic             rsp_take, rsp_drop, buf_push, buf_pop, inst_valid;
  logic [CNT_W:0]   occupancy, inflight;

  // Pending discards after a redirect: a response arriving in the redirect
  // cycle consumes one of them; never goes below zero.
  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W:0] a,
                                               input logic            dec);
    if (dec && a == '0) return '0;
    return CNT_W'(a - (CNT_W + 1)'(dec));
  endfunction

  assign redirect   = bus.redirect_valid_in;
  assign misaligned = redirect && (bus.redirect_pc_in[1:0] != 2'b00);
  assign occupancy  = {1'b0, outstanding} + {1'b0, buf_count};
  assign inflight   = {1'b0, outstanding} + {1'b0, discard_cnt};

  always_comb begin
    state_next = state;
    req_valid  = 1'b0;
    if (redirect)
      state_next = misaligned ? ST_HALT : ST_RUN;
    else if (rsp_take && bus.imem_rsp_err_in)
      state_next = ST_HALT;
    req_valid = (state == ST_RUN) && !redirect && !rst_in &&
                (occupancy < DEPTH_L) && (inflight < DEPTH_L);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= ST_RUN;
    else        state <= state_next;
  end

  assign req_fire = req_valid && bus.imem_req_ready_in;
  assign rsp_take = bus.imem_rsp_valid_in && (discard_cnt == '0) && !pcq_empty;
  assign rsp_drop = bus.imem_rsp_valid_in && (discard_cnt != '0);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pc          <= RESET_PC;
      discard_cnt <= '0;
    end else if (redirect) begin
      pc          <= {bus.redirect_pc_in[31:2], 2'b00};
      discard_cnt <= sat_dec(inflight, bus.imem_rsp_valid_in);
    end else begin
      if (req_fire) pc          <= pc + 32'd4;
      if (rsp_drop) discard_cnt <= discard_cnt - CNT_W'(1);
    end
  end

  fetch_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_pc_fifo (
    .clk       (clk_in),
    .rst       (rst_in),
    .flush     (redirect),
    .push      (req_fire),
    .push_data (pc),
    .pop       (rsp_take),
    .head_data (pcq_head),
    .count     (outstanding),
    .empty     (pcq_empty)
  );

  always_comb begin
    buf_push_data = fault_entry(bus.redirect_pc_in);
    if (!misaligned) begin
      buf_push_data.fault = bus.imem_rsp_err_in;
      buf_push_data.pc    = pcq_head;
      buf_push_data.inst  = bus.imem_rsp_err_in ? 32'h0 : bus.imem_rsp_data_in;
    end
  end

  assign buf_push   = misaligned || (!redirect && rsp_take);
  assign inst_valid = !rst_in && !buf_empty;
  assign buf_pop    = inst_valid && bus.inst_ready_in && !redirect;

  // Instruction buffer: pushed entries appear at the head one cycle later.
  fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_inst_fifo (
    .clk       (clk_in),
    .rst       (rst_in),
    .flush     (redirect),
    .push      (buf_push),
    .push_data (buf_push_data),
    .pop       (buf_pop),
    .head_data (buf_head),
    .count     (buf_count),
    .empty     (buf_empty)
  );

  assign bus.imem_req_valid_out = req_valid;
  assign bus.imem_req_addr_out  = pc;
  assign bus.inst_valid_out     = inst_valid;
  assign bus.inst_out           = inst_valid ? buf_head.inst : 32'h0;
  assign bus.inst_pc_out        = inst_valid ? buf_head.pc : 32'h0;
  assign bus.inst_fault_out     = inst_valid && buf_head.fault;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit. A small in-order memory returns
// ~addr one cycle after each accepted request, flags an access fault at
// err_addr, and can be told to hold its responses (rsp_en = 0).
module tb_instr_fetch_unit;
  logic clk = 1'b0;
  logic rst_in;
  always #5 clk = ~clk;

  instr_fetch_unit_if ifc();

  instr_fetch_unit #(.RESET_PC(32'h8000_0000), .DEPTH(2)) dut (
    .clk_in (clk),
    .rst_in (rst_in),
    .bus    (ifc.master)
  );

  int          checks   = 0;
  int          failures = 0;
  int          req_count = 0;
  int          c0;
  logic        rsp_en;
  logic [31:0] err_addr;
  logic [31:0] mq[$];

  // Memory: accepted requests queue up, the oldest is answered next cycle.
  always @(posedge clk) begin
    if (rst_in) begin
      mq.delete();
      ifc.imem_rsp_valid_in <= 1'b0;
      ifc.imem_rsp_data_in  <= 32'h0;
      ifc.imem_rsp_err_in   <= 1'b0;
    end else begin
      if (ifc.imem_req_valid_out && ifc.imem_req_ready_in) begin
        mq.push_back(ifc.imem_req_addr_out);
        req_count <= req_count + 1;
      end
      if (rsp_en && mq.size() > 0) begin
        ifc.imem_rsp_valid_in <= 1'b1;
        ifc.imem_rsp_data_in  <= ~mq[0];
        ifc.imem_rsp_err_in   <= (mq[0] == err_addr);
        void'(mq.pop_front());
      end else begin
        ifc.imem_rsp_valid_in <= 1'b0;
        ifc.imem_rsp_data_in  <= 32'h0;
        ifc.imem_rsp_err_in   <= 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    ifc.redirect_pc_in    = pc;
    ifc.redirect_valid_in = 1'b1;
    @(negedge clk);
    ifc.redirect_valid_in = 1'b0;
  endtask

  // Waits (bounded) for the next decoder entry, checks it, lets it pop.
  task automatic wait_inst(input string tag, input logic [31:0] pc,
                           input logic [31:0] inst, input logic fault);
    int n = 0;
    while (ifc.inst_valid_out !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 32'(ifc.inst_valid_out), 32'h1);
    chk({tag, "_pc"},    ifc.inst_pc_out, pc);
    chk({tag, "_inst"},  ifc.inst_out, inst);
    chk({tag, "_fault"}, 32'(ifc.inst_fault_out), 32'(fault));
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in                = 1'b1;
    ifc.redirect_valid_in = 1'b0;
    ifc.redirect_pc_in    = 32'h0;
    ifc.imem_req_ready_in = 1'b1;
    ifc.inst_ready_in     = 1'b1;
    rsp_en                = 1'b1;
    err_addr              = 32'h0000_0001;

    step(3);
    chk("rst_req_valid",  32'(ifc.imem_req_valid_out), 32'h0);
    chk("rst_inst_valid", 32'(ifc.inst_valid_out), 32'h0);
    chk("rst_inst_out",   ifc.inst_out, 32'h0);
    chk("rst_inst_pc",    ifc.inst_pc_out, 32'h0);
    chk("rst_inst_fault", 32'(ifc.inst_fault_out), 32'h0);

    // Scenario 1: streaming fetch from the reset PC.
    rst_in = 1'b0;
    #1;
    chk("first_req_valid", 32'(ifc.imem_req_valid_out), 32'h1);
    chk("first_req_addr",  ifc.imem_req_addr_out, 32'h8000_0000);
    wait_inst("s1_0", 32'h8000_0000, 32'h7FFF_FFFF, 1'b0);
    wait_inst("s1_1", 32'h8000_0004, 32'h7FFF_FFFB, 1'b0);
    wait_inst("s1_2", 32'h8000_0008, 32'h7FFF_FFF7, 1'b0);
    wait_inst("s1_3", 32'h8000_000C, 32'h7FFF_FFF3, 1'b0);

    // Scenario 2: decoder stalled -> two requests, stable head, then resume.
    ifc.inst_ready_in = 1'b0;
    redirect_to(32'h8000_0040);
    c0 = req_count;
    step(10);
    chk("s2_req_issued",  32'(req_count - c0), 32'd2);
    chk("s2_req_blocked", 32'(ifc.imem_req_valid_out), 32'h0);
    chk("s2_head_pc",     ifc.inst_pc_out, 32'h8000_0040);
    chk("s2_head_inst",   ifc.inst_out, 32'h7FFF_FFBF);
    step(3);
    chk("s2_hold_pc",     ifc.inst_pc_out, 32'h8000_0040);
    chk("s2_hold_inst",   ifc.inst_out, 32'h7FFF_FFBF);
    chk("s2_hold_reqs",   32'(req_count - c0), 32'd2);
    ifc.inst_ready_in = 1'b1;
    wait_inst("s2_0", 32'h8000_0040, 32'h7FFF_FFBF, 1'b0);
    wait_inst("s2_1", 32'h8000_0044, 32'h7FFF_FFBB, 1'b0);
    wait_inst("s2_2", 32'h8000_0048, 32'h7FFF_FFB7, 1'b0);

    // Scenario 3: redirect while both slots are outstanding.
    rsp_en = 1'b0;
    redirect_to(32'h8000_0080);
    step(6);
    chk("s3_req_blocked", 32'(ifc.imem_req_valid_out), 32'h0);
    redirect_to(32'h8000_0100);
    rsp_en = 1'b1;
    wait_inst("s3_0", 32'h8000_0100, 32'h7FFF_FEFF, 1'b0);
    wait_inst("s3_1", 32'h8000_0104, 32'h7FFF_FEFB, 1'b0);

    // Scenario 4: access fault at 8000_0008 halts fetching.
    err_addr = 32'h8000_0008;
    redirect_to(32'h8000_0000);
    wait_inst("s4_0", 32'h8000_0000, 32'h7FFF_FFFF, 1'b0);
    wait_inst("s4_1", 32'h8000_0004, 32'h7FFF_FFFB, 1'b0);
    wait_inst("s4_f", 32'h8000_0008, 32'h0000_0000, 1'b1);
    step(3);
    c0 = req_count;
    step(8);
    chk("s4_no_reqs",  32'(req_count - c0), 32'd0);
    chk("s4_req_low",  32'(ifc.imem_req_valid_out), 32'h0);

    // Scenario 5: misaligned redirect faults without a request; then resume.
    err_addr = 32'h0000_0001;
    c0 = req_count;
    redirect_to(32'h8000_0102);
    wait_inst("s5_f", 32'h8000_0102, 32'h0000_0000, 1'b1);
    step(4);
    chk("s5_no_reqs", 32'(req_count - c0), 32'd0);
    chk("s5_req_low", 32'(ifc.imem_req_valid_out), 32'h0);
    redirect_to(32'h8000_0200);
    wait_inst("s5_0", 32'h8000_0200, 32'h7FFF_FDFF, 1'b0);
    wait_inst("s5_1", 32'h8000_0204, 32'h7FFF_FDFB, 1'b0);

    // Scenario 6: PC wrap-around.
    redirect_to(32'hFFFF_FFF8);
    wait_inst("s6_0", 32'hFFFF_FFF8, 32'h0000_0007, 1'b0);
    wait_inst("s6_1", 32'hFFFF_FFFC, 32'h0000_0003, 1'b0);
    wait_inst("s6_2", 32'h0000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_inst("s6_3", 32'h0000_0004, 32'hFFFF_FFFB, 1'b0);

    // Reset in mid-stream restarts from the reset PC.
    rst_in = 1'b1;
    #1;
    chk("mid_rst_req_valid",  32'(ifc.imem_req_valid_out), 32'h0);
    chk("mid_rst_inst_valid", 32'(ifc.inst_valid_out), 32'h0);
    chk("mid_rst_inst_pc",    ifc.inst_pc_out, 32'h0);
    @(negedge clk);
    rst_in = 1'b0;
    #1;
    chk("mid_rst_first_valid", 32'(ifc.imem_req_valid_out), 32'h1);
    chk("mid_rst_first_addr",  ifc.imem_req_addr_out, 32'h8000_0000);
    wait_inst("r_0", 32'h8000_0000, 32'h7FFF_FFFF, 1'b0);
    wait_inst("r_1", 32'h8000_0004, 32'h7FFF_FFFB, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h8000_0000, PC of the first fetch after reset.
REQ-002 Parameter: DEPTH, 2, instruction buffer entries, which is also the maximum number of outstanding requests.
REQ-003 clk_in  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_in  input  1  synchronous, active-high reset.
REQ-005 redirect_valid_in  input  1  flush the unit and restart fetch at redirect_pc_in.
REQ-006 redirect_pc_in  input  32  new fetch PC.
REQ-007 imem_req_valid_out  output  1  fetch request valid.
REQ-008 imem_req_addr_out  output  32  word address of the request.
REQ-009 imem_req_ready_in  input  1  memory accepts the request.
REQ-010 imem_rsp_valid_in  input  1  response valid; responses arrive in request order.
REQ-011 imem_rsp_data_in  input  32  fetched instruction word.
REQ-012 imem_rsp_err_in  input  1  access fault on this response.
REQ-013 inst_valid_out  output  1  instruction available to the type decoder.
REQ-014 inst_out  output  32  instruction word; bits [6:0] carry the opcode consumed by the decoder.
REQ-015 inst_pc_out  output  32  PC of inst_out.
REQ-016 inst_fault_out  output  1  the entry is a fetch fault; when set, inst_out = 0.
REQ-017 inst_ready_in  input  1  decoder accepts the entry.

Function
REQ-018 Two states: RUN, which issues fetches, and HALT, which issues no requests; exit from HALT is by redirect only.
REQ-019 Request issue rule:
  - imem_req_valid_out = RUN && !redirect_valid_in && (outstanding + buffer_count < DEPTH).
  - The request is accepted when imem_req_ready_in is also high.
REQ-020 On acceptance, the fetch PC SHALL increment by 4 (mod 2^32) and outstanding SHALL increment by 1.
REQ-021 Response handling: a response with discard_cnt = 0 SHALL be pushed into the buffer with its PC (a PC FIFO tracks in-flight PCs) and SHALL decrement outstanding.
REQ-022 A response with imem_rsp_err_in = 1 SHALL push a fault entry and move the unit to HALT.
REQ-023 Buffer latency: an entry pushed in cycle N SHALL be visible on inst_*_out in cycle N+1.
REQ-024 The buffer is a FIFO: pop when inst_valid_out && inst_ready_in. Simultaneous push and pop at full SHALL be legal, and the buffer can never overflow given REQ-019.
REQ-025 inst_*_out SHALL hold stable while inst_valid_out = 1 && inst_ready_in = 0.
REQ-026 Redirect in cycle N:
  - The buffer is flushed.
  - The fetch PC becomes {redirect_pc_in[31:2], 2'b00}.
  - discard_cnt becomes discard_cnt + outstanding - (response arriving in cycle N ? 1 : 0), saturating at 0.
  - outstanding becomes 0.
  - The state becomes RUN.
REQ-027 A response arriving while discard_cnt > 0 SHALL be dropped and SHALL decrement discard_cnt.
REQ-028 Misaligned redirect (redirect_pc_in[1:0] != 0): no request is issued; one fault entry is pushed with inst_pc_out = redirect_pc_in; the state becomes HALT.
REQ-029 Redirect has priority over every same-cycle response push and over any pop.
REQ-030 Wrap-around: PC 32'hFFFF_FFFC SHALL be followed by 32'h0000_0000 with no fault.
REQ-031 New requests SHALL be blocked while outstanding + discard_cnt = DEPTH, so counters never exceed DEPTH.

Reset
REQ-032 While rst_in = 1 in a cycle:
  - fetch PC = RESET_PC; state = RUN.
  - outstanding = 0; discard_cnt = 0; buffer empty.
  - inst_valid_out = 0; inst_out = 0; inst_pc_out = 0; inst_fault_out = 0; imem_req_valid_out = 0.
REQ-033 A reset asserted mid-operation SHALL drop all in-flight state; responses arriving after reset to requests made before reset are the memory's responsibility to squash.
REQ-034 The first request SHALL be presented in the first cycle after rst_in falls.

Structure
REQ-035 RESET_PC default, the DEPTH default, and the opcode constants shared with the type decoder belong in the shared defines file.
REQ-036 One sub-module is used: fetch_fifo, a parameterised synchronous FIFO holding {fault, pc, inst}, instantiated for the buffer.
REQ-037 The in-flight PC tracking SHALL be either a second fetch_fifo instance or a register pair.

Verification
REQ-038 Scenario 1: reset, then ready always high and a 1-cycle memory -> requests to 8000_0000, 8000_0004, ...; decoder sees in-order PCs at one per cycle.
REQ-039 Scenario 2: inst_ready_in held low -> at most 2 requests issued; inst_out stable; no request until a pop.
REQ-040 Scenario 3: redirect to 8000_0100 with 2 requests outstanding -> both responses dropped; next delivered inst_pc_out = 8000_0100.
REQ-041 Scenario 4: response with imem_rsp_err_in = 1 at PC 8000_0008 -> fault entry with inst_out = 0; no further requests until redirect.
REQ-042 Scenario 5: redirect to 8000_0102 -> fault entry with pc 8000_0102 and zero requests; then redirect to 8000_0200 resumes fetch.
REQ-043 Scenario 6: redirect to FFFF_FFF8 -> fetches FFFF_FFF8, FFFF_FFFC, 0000_0000 with no fault.
